// File: rtl/lm80c_kbd_event_arbiter.sv
// Merges live PS/2 key events with host-injected keystrokes; each injected key is
// expanded into a timed press/hold/release/gap sequence, and live events always win.
module lm80c_kbd_event_arbiter #(
    parameter int FIFO_DEPTH  = 16,
    parameter int HOLD_CYCLES = 1000000,
    parameter int GAP_CYCLES  = 1000000,
    parameter int CNT_W       = 21
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_valid,
    input  logic [9:0]                    ps2_key,
    input  logic                          ps2_status,
    input  logic                          inj_wr,
    input  logic [9:0]                    inj_key,
    input  logic                          inj_abort,
    output logic                          inj_full,
    output logic [$clog2(FIFO_DEPTH):0]   inj_count,
    output logic                          inj_ovf,
    output logic                          busy,
    output logic                          out_valid,
    output logic [9:0]                    out_key,
    output logic                          out_status
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_HOLD,
        S_RELEASE,
        S_GAP
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [9:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [9:0]       cur_key;
    logic             push, pop, emit, emit_status;

    assign inj_full  = (count == DEPTH_C);
    assign inj_count = count;
    assign push      = inj_wr && !inj_abort && !inj_full;

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        pop         = 1'b0;
        emit        = 1'b0;
        emit_status = 1'b0;
        case (state)
            S_IDLE: begin
                if (!inj_abort && count != '0) begin
                    pop        = 1'b1;
                    state_next = S_PRESS;
                end
            end
            S_PRESS: begin
                if (inj_abort) begin
                    state_next = S_IDLE;
                end else if (!ps2_valid) begin
                    emit        = 1'b1;
                    emit_status = 1'b1;
                    cnt_next    = HOLD_LOAD;
                    state_next  = S_HOLD;
                end
            end
            S_HOLD: begin
                // An abort mid-hold must still release the key the emulated machine sees as down.
                if (inj_abort) begin
                    state_next = S_RELEASE;
                end else if (cnt == CNT_ONE) begin
                    cnt_next   = '0;
                    state_next = S_RELEASE;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            S_RELEASE: begin
                if (!inj_abort && !ps2_valid) begin
                    emit       = 1'b1;
                    cnt_next   = GAP_LOAD;
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // FIFO bookkeeping; pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            inj_ovf <= 1'b0;
        end else if (inj_abort) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            inj_ovf <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (inj_wr && inj_full) inj_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= inj_key;
        if (pop)  cur_key     <= mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_key    <= '0;
            out_status <= 1'b0;
            busy       <= 1'b0;
        end else begin
            out_valid <= ps2_valid || emit;
            busy      <= (state != S_IDLE) || (count != '0);
            if (ps2_valid) begin
                out_key    <= ps2_key;
                out_status <= ps2_status;
            end else if (emit) begin
                out_key    <= cur_key;
                out_status <= emit_status;
            end
        end
    end

endmodule

// File: tb/tb_lm80c_kbd_event_arbiter.sv
// Directed bench for lm80c_kbd_event_arbiter with HOLD=4, GAP=3, FIFO depth 4.
// Cycle n is the interval after rising edge n; the edge sampling a push is the test's t0.
module tb_lm80c_kbd_event_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_valid = 1'b0;
    logic [9:0] ps2_key = '0;
    logic       ps2_status = 1'b0;
    logic       inj_wr = 1'b0;
    logic [9:0] inj_key = '0;
    logic       inj_abort = 1'b0;
    logic       inj_full, inj_ovf, busy, out_valid, out_status;
    logic [2:0] inj_count;
    logic [9:0] out_key;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    int         ev_cyc[$];
    logic [9:0] ev_key[$];
    logic       ev_st[$];

    lm80c_kbd_event_arbiter #(
        .FIFO_DEPTH(4), .HOLD_CYCLES(4), .GAP_CYCLES(3), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .ps2_valid(ps2_valid), .ps2_key(ps2_key), .ps2_status(ps2_status),
        .inj_wr(inj_wr), .inj_key(inj_key), .inj_abort(inj_abort),
        .inj_full(inj_full), .inj_count(inj_count), .inj_ovf(inj_ovf), .busy(busy),
        .out_valid(out_valid), .out_key(out_key), .out_status(out_status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            ev_cyc.push_back(cyc);
            ev_key.push_back(out_key);
            ev_st.push_back(out_status);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_events();
        ev_cyc.delete();
        ev_key.delete();
        ev_st.delete();
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_key(input logic [9:0] k, output int t0);
        @(negedge clk);
        inj_wr  = 1'b1;
        inj_key = k;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        inj_wr = 1'b0;
    endtask

    task automatic test_reset();
        int t0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({out_valid, out_key, out_status, inj_count, inj_full, inj_ovf, busy} !== '0)
            $display("FAIL por_outputs: got v=%b k=%h s=%b cnt=%0d full=%b ovf=%b busy=%b, need all 0",
                     out_valid, out_key, out_status, inj_count, inj_full, inj_ovf, busy);
        else n_pass++;
        reset = 1'b0;
        clear_events();
        push_key(10'h02A, t0);
        wait_cyc(t0 + 3);
        n_total++;
        if (ev_cyc.size() !== 1 || out_key !== 10'h02A)
            $display("FAIL rst_pre_press: got %0d events key=%h, need 1 event key=02a", ev_cyc.size(), out_key);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if ({out_valid, out_key, out_status, inj_count, busy} !== '0)
            $display("FAIL rst_async_clear: got v=%b k=%h s=%b cnt=%0d busy=%b, need all 0",
                     out_valid, out_key, out_status, inj_count, busy);
        else n_pass++;
        clear_events();
        @(negedge clk);
        reset = 1'b0;
        wait_cyc(cyc + 12);
        n_total++;
        if (ev_cyc.size() !== 0)
            $display("FAIL rst_no_release: got %0d events, need 0", ev_cyc.size());
        else n_pass++;
        n_total++;
        if (busy !== 1'b0)
            $display("FAIL rst_busy: got %b, need 0", busy);
        else n_pass++;
    endtask

    task automatic test_live();
        int t0;
        clear_events();
        @(negedge clk);
        ps2_valid  = 1'b1;
        ps2_key    = 10'h01C;
        ps2_status = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        n_total++;
        if (out_valid !== 1'b1 || out_key !== 10'h01C || out_status !== 1'b1)
            $display("FAIL live_event: got v=%b k=%h s=%b, need v=1 k=01c s=1", out_valid, out_key, out_status);
        else n_pass++;
        @(negedge clk);
        ps2_valid = 1'b0;
        wait_cyc(t0 + 4);
        n_total++;
        if (ev_cyc.size() !== 1 || ev_cyc[0] !== t0)
            $display("FAIL live_single_strobe: got %0d events, need exactly 1 at cycle %0d", ev_cyc.size(), t0);
        else n_pass++;
        n_total++;
        if (out_key !== 10'h01C || out_status !== 1'b1)
            $display("FAIL live_hold_value: got k=%h s=%b, need k=01c s=1", out_key, out_status);
        else n_pass++;
    endtask

    task automatic test_single();
        int t0;
        clear_events();
        push_key(10'h015, t0);
        n_total++;
        if (inj_count !== 3'd1)
            $display("FAIL single_count_push: got %0d, need 1", inj_count);
        else n_pass++;
        wait_cyc(t0 + 1);
        n_total++;
        if (inj_count !== 3'd0)
            $display("FAIL single_count_pop: got %0d, need 0", inj_count);
        else n_pass++;
        wait_cyc(t0 + 9);
        n_total++;
        if (busy !== 1'b1)
            $display("FAIL single_busy_c9: got %b, need 1", busy);
        else n_pass++;
        wait_cyc(t0 + 10);
        n_total++;
        if (busy !== 1'b0)
            $display("FAIL single_busy_c10: got %b, need 0", busy);
        else n_pass++;
        wait_cyc(t0 + 14);
        n_total++;
        if (ev_cyc.size() !== 2)
            $display("FAIL single_event_count: got %0d, need 2", ev_cyc.size());
        else begin
            n_pass++;
            n_total++;
            if (ev_cyc[0] - t0 !== 2 || ev_key[0] !== 10'h015 || ev_st[0] !== 1'b1)
                $display("FAIL single_press: got cyc+%0d k=%h s=%b, need cyc+2 k=015 s=1",
                         ev_cyc[0] - t0, ev_key[0], ev_st[0]);
            else n_pass++;
            n_total++;
            if (ev_cyc[1] - t0 !== 6 || ev_key[1] !== 10'h015 || ev_st[1] !== 1'b0)
                $display("FAIL single_release: got cyc+%0d k=%h s=%b, need cyc+6 k=015 s=0",
                         ev_cyc[1] - t0, ev_key[1], ev_st[1]);
            else n_pass++;
        end
    endtask

    task automatic test_collision();
        int t0;
        int         exp_c[3] = '{2, 3, 7};
        logic [9:0] exp_k[3] = '{10'h016, 10'h015, 10'h015};
        logic       exp_s[3] = '{1'b1, 1'b1, 1'b0};
        clear_events();
        push_key(10'h015, t0);
        wait_cyc(t0 + 1);
        ps2_valid  = 1'b1;
        ps2_key    = 10'h016;
        ps2_status = 1'b1;
        wait_cyc(t0 + 2);
        ps2_valid = 1'b0;
        wait_cyc(t0 + 16);
        n_total++;
        if (ev_cyc.size() !== 3)
            $display("FAIL coll_event_count: got %0d, need 3", ev_cyc.size());
        else begin
            n_pass++;
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (ev_cyc[i] - t0 !== exp_c[i] || ev_key[i] !== exp_k[i] || ev_st[i] !== exp_s[i])
                    $display("FAIL coll_event%0d: got cyc+%0d k=%h s=%b, need cyc+%0d k=%h s=%b", i,
                             ev_cyc[i] - t0, ev_key[i], ev_st[i], exp_c[i], exp_k[i], exp_s[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_overflow();
        int t0;
        int ec;
        logic [9:0] ek;
        clear_events();
        push_key(10'h011, t0);
        wait_cyc(t0 + 2);
        for (int i = 0; i < 5; i++) begin
            inj_wr  = 1'b1;
            inj_key = 10'h021 + 10'(i);
            @(negedge clk);
        end
        inj_wr = 1'b0;
        n_total++;
        if (inj_count !== 3'd4 || inj_full !== 1'b1 || inj_ovf !== 1'b1)
            $display("FAIL ovf_flags: got cnt=%0d full=%b ovf=%b, need cnt=4 full=1 ovf=1",
                     inj_count, inj_full, inj_ovf);
        else n_pass++;
        for (int i = 0; i < 300 && busy !== 1'b0; i++) @(negedge clk);
        n_total++;
        if (busy !== 1'b0)
            $display("FAIL ovf_drain_timeout: busy=%b, need 0 within 300 cycles", busy);
        else n_pass++;
        n_total++;
        if (ev_cyc.size() !== 10)
            $display("FAIL ovf_event_count: got %0d, need 10", ev_cyc.size());
        else begin
            n_pass++;
            for (int i = 0; i < 10; i++) begin
                if (i < 2) begin
                    ek = 10'h011;
                    ec = (i == 0) ? 2 : 6;
                end else begin
                    ek = 10'h021 + 10'((i - 2) / 2);
                    ec = 11 + 9 * ((i - 2) / 2) + ((i % 2 == 1) ? 4 : 0);
                end
                n_total++;
                if (ev_cyc[i] - t0 !== ec || ev_key[i] !== ek || ev_st[i] !== (i % 2 == 0))
                    $display("FAIL ovf_event%0d: got cyc+%0d k=%h s=%b, need cyc+%0d k=%h s=%b", i,
                             ev_cyc[i] - t0, ev_key[i], ev_st[i], ec, ek, (i % 2 == 0));
                else n_pass++;
            end
        end
    endtask

    task automatic test_abort();
        int t0;
        clear_events();
        @(negedge clk);
        inj_wr  = 1'b1;
        inj_key = 10'h031;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        inj_key = 10'h032;
        @(negedge clk);
        inj_key = 10'h033;
        @(negedge clk);
        inj_wr = 1'b0;
        n_total++;
        if (inj_count !== 3'd2 || inj_ovf !== 1'b1)
            $display("FAIL abort_pre: got cnt=%0d ovf=%b, need cnt=2 ovf=1", inj_count, inj_ovf);
        else n_pass++;
        wait_cyc(t0 + 3);
        inj_abort = 1'b1;
        wait_cyc(t0 + 4);
        inj_abort = 1'b0;
        n_total++;
        if (inj_count !== 3'd0 || inj_ovf !== 1'b0)
            $display("FAIL abort_flush: got cnt=%0d ovf=%b, need cnt=0 ovf=0", inj_count, inj_ovf);
        else n_pass++;
        wait_cyc(t0 + 20);
        n_total++;
        if (ev_cyc.size() !== 2)
            $display("FAIL abort_event_count: got %0d, need 2", ev_cyc.size());
        else begin
            n_pass++;
            n_total++;
            if (ev_cyc[0] - t0 !== 2 || ev_key[0] !== 10'h031 || ev_st[0] !== 1'b1)
                $display("FAIL abort_press: got cyc+%0d k=%h s=%b, need cyc+2 k=031 s=1",
                         ev_cyc[0] - t0, ev_key[0], ev_st[0]);
            else n_pass++;
            n_total++;
            if (ev_cyc[1] - t0 !== 5 || ev_key[1] !== 10'h031 || ev_st[1] !== 1'b0)
                $display("FAIL abort_release: got cyc+%0d k=%h s=%b, need cyc+5 k=031 s=0",
                         ev_cyc[1] - t0, ev_key[1], ev_st[1]);
            else n_pass++;
        end
        n_total++;
        if (busy !== 1'b0 || inj_count !== 3'd0)
            $display("FAIL abort_idle: got busy=%b cnt=%0d, need busy=0 cnt=0", busy, inj_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_live();
        test_single();
        test_collision();
        test_overflow();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
